// File: rtl/fp_exponent_align.sv
// Front-end alignment stage of the single-precision FP add/sub datapath.
// Two registered stages: unpack/order/classify, then sticky right-shift of the smaller significand.
module fp_exponent_align #(
  parameter int MANT_W = 23,
  parameter int EXP_W  = 8,
  parameter int EXT_W  = 27
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [MANT_W+EXP_W:0]        op_a,
  input  logic [MANT_W+EXP_W:0]        op_b,
  input  logic                         op_sub,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [EXP_W-1:0]             exp_max,
  output logic [EXT_W-1:0]             mant_large,
  output logic [EXT_W-1:0]             mant_small,
  output logic                         sign_large,
  output logic                         eff_sub,
  output logic                         swap,
  output logic                         is_nan,
  output logic                         is_inf
);

  localparam int SIG_W = MANT_W + 1;

  // Handshake: a beat moves on valid & ready; a stalled output (out_valid & !out_ready)
  // holds every output register, and stage 1 frees its slot only when it advances.
  logic              s1_valid_q, s1_valid_d;
  logic [EXP_W-1:0]  s1_exp_q, s1_exp_d;
  logic [EXP_W-1:0]  s1_diff_q, s1_diff_d;
  logic [SIG_W-1:0]  s1_sig_l_q, s1_sig_l_d;
  logic [SIG_W-1:0]  s1_sig_s_q, s1_sig_s_d;
  logic              s1_sign_q, s1_sign_d;
  logic              s1_eff_sub_q, s1_eff_sub_d;
  logic              s1_swap_q, s1_swap_d;
  logic              s1_nan_q, s1_nan_d;
  logic              s1_inf_q, s1_inf_d;

  logic              out_valid_q, out_valid_d;
  logic [EXP_W-1:0]  exp_max_q, exp_max_d;
  logic [EXT_W-1:0]  mant_large_q, mant_large_d;
  logic [EXT_W-1:0]  mant_small_q, mant_small_d;
  logic              sign_large_q, sign_large_d;
  logic              eff_sub_q, eff_sub_d;
  logic              swap_q, swap_d;
  logic              is_nan_q, is_nan_d;
  logic              is_inf_q, is_inf_d;

  logic s1_adv, in_accept;

  assign s1_adv    = s1_valid_q & (~out_valid_q | out_ready);
  assign in_ready  = ~s1_valid_q | s1_adv;
  assign in_accept = in_valid & in_ready;

  // Stage 1: unpack, magnitude order, classify specials.
  logic [EXP_W-1:0]  ea, eb, effexp_a, effexp_b;
  logic [MANT_W-1:0] fa, fb;
  logic              sb_eff, eff_sub_c, swap_c;
  logic              nan_a, nan_b, inf_a, inf_b, nan_c;

  always_comb begin
    ea        = op_a[MANT_W+EXP_W-1:MANT_W];
    eb        = op_b[MANT_W+EXP_W-1:MANT_W];
    fa        = op_a[MANT_W-1:0];
    fb        = op_b[MANT_W-1:0];
    effexp_a  = (ea == '0) ? EXP_W'(1) : ea;
    effexp_b  = (eb == '0) ? EXP_W'(1) : eb;
    sb_eff    = op_b[MANT_W+EXP_W] ^ op_sub;
    eff_sub_c = op_a[MANT_W+EXP_W] ^ sb_eff;
    swap_c    = {eb, fb} > {ea, fa};
    nan_a     = (&ea) & (|fa);
    nan_b     = (&eb) & (|fb);
    inf_a     = (&ea) & ~(|fa);
    inf_b     = (&eb) & ~(|fb);
    nan_c     = nan_a | nan_b | (inf_a & inf_b & eff_sub_c);

    s1_valid_d   = s1_valid_q;
    s1_exp_d     = s1_exp_q;
    s1_diff_d    = s1_diff_q;
    s1_sig_l_d   = s1_sig_l_q;
    s1_sig_s_d   = s1_sig_s_q;
    s1_sign_d    = s1_sign_q;
    s1_eff_sub_d = s1_eff_sub_q;
    s1_swap_d    = s1_swap_q;
    s1_nan_d     = s1_nan_q;
    s1_inf_d     = s1_inf_q;

    if (in_accept) begin
      s1_valid_d   = 1'b1;
      s1_swap_d    = swap_c;
      s1_eff_sub_d = eff_sub_c;
      s1_nan_d     = nan_c;
      s1_inf_d     = ~nan_c & (inf_a | inf_b);
      if (swap_c) begin
        s1_exp_d   = effexp_b;
        s1_diff_d  = effexp_b - effexp_a;
        s1_sig_l_d = {eb != '0, fb};
        s1_sig_s_d = {ea != '0, fa};
        s1_sign_d  = sb_eff;
      end else begin
        s1_exp_d   = effexp_a;
        s1_diff_d  = effexp_a - effexp_b;
        s1_sig_l_d = {ea != '0, fa};
        s1_sig_s_d = {eb != '0, fb};
        s1_sign_d  = op_a[MANT_W+EXP_W];
      end
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2: right-shift with all shifted-out bits folded into the LSB.
  logic [EXT_W-1:0] t, shifted, lost_mask;

  always_comb begin
    t         = {s1_sig_s_q, 3'b000};
    shifted   = t >> s1_diff_q;
    lost_mask = ~({EXT_W{1'b1}} << s1_diff_q);

    out_valid_d  = s1_adv | (out_valid_q & ~out_ready);
    exp_max_d    = exp_max_q;
    mant_large_d = mant_large_q;
    mant_small_d = mant_small_q;
    sign_large_d = sign_large_q;
    eff_sub_d    = eff_sub_q;
    swap_d       = swap_q;
    is_nan_d     = is_nan_q;
    is_inf_d     = is_inf_q;

    if (s1_adv) begin
      exp_max_d    = s1_exp_q;
      mant_large_d = {s1_sig_l_q, 3'b000};
      if (s1_diff_q < EXP_W'(EXT_W))
        mant_small_d = shifted | {{(EXT_W-1){1'b0}}, |(t & lost_mask)};
      else
        mant_small_d = {{(EXT_W-1){1'b0}}, |t};
      sign_large_d = s1_sign_q;
      eff_sub_d    = s1_eff_sub_q;
      swap_d       = s1_swap_q;
      is_nan_d     = s1_nan_q;
      is_inf_d     = s1_inf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_exp_q     <= '0;
      s1_diff_q    <= '0;
      s1_sig_l_q   <= '0;
      s1_sig_s_q   <= '0;
      s1_sign_q    <= 1'b0;
      s1_eff_sub_q <= 1'b0;
      s1_swap_q    <= 1'b0;
      s1_nan_q     <= 1'b0;
      s1_inf_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      exp_max_q    <= '0;
      mant_large_q <= '0;
      mant_small_q <= '0;
      sign_large_q <= 1'b0;
      eff_sub_q    <= 1'b0;
      swap_q       <= 1'b0;
      is_nan_q     <= 1'b0;
      is_inf_q     <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_exp_q     <= s1_exp_d;
      s1_diff_q    <= s1_diff_d;
      s1_sig_l_q   <= s1_sig_l_d;
      s1_sig_s_q   <= s1_sig_s_d;
      s1_sign_q    <= s1_sign_d;
      s1_eff_sub_q <= s1_eff_sub_d;
      s1_swap_q    <= s1_swap_d;
      s1_nan_q     <= s1_nan_d;
      s1_inf_q     <= s1_inf_d;
      out_valid_q  <= out_valid_d;
      exp_max_q    <= exp_max_d;
      mant_large_q <= mant_large_d;
      mant_small_q <= mant_small_d;
      sign_large_q <= sign_large_d;
      eff_sub_q    <= eff_sub_d;
      swap_q       <= swap_d;
      is_nan_q     <= is_nan_d;
      is_inf_q     <= is_inf_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign exp_max    = exp_max_q;
  assign mant_large = mant_large_q;
  assign mant_small = mant_small_q;
  assign sign_large = sign_large_q;
  assign eff_sub    = eff_sub_q;
  assign swap       = swap_q;
  assign is_nan     = is_nan_q;
  assign is_inf     = is_inf_q;

endmodule
